// File: rtl/sram_scheduler_if.sv
// ---------------------------------------------------------------------------
// sram_scheduler_if
// Bundles every signal between the SRAM scheduler and its surroundings.
// This covers the video line fetch, the pen plot, the erase sweep and the
// SRAM controller command port.
//   slave  modport : the scheduler's view of the bundle
//                    (requests and SRAM status in; grants and commands out).
//   master modport : the environment's view
//                    (requesters plus the SRAM controller).
// Signals:
//   vid_req/vid_addr -> vid_grant/vid_valid/vid_data   video fetch
//   pen_req/pen_x/pen_y -> pen_ack                     pixel plot
//   erase_req -> erase_busy                            background erase
//   ready/data_read -> address/data_write/read/write   SRAM controller
//   state                                              debug state code
// ---------------------------------------------------------------------------
interface sram_scheduler_if #(
   parameter int ADDR_W = 18
);
   logic              vid_req;
   logic [ADDR_W-1:0] vid_addr;
   logic              vid_grant;
   logic              vid_valid;
   logic [15:0]       vid_data;
   logic              pen_req;
   logic [9:0]        pen_x;
   logic [9:0]        pen_y;
   logic              pen_ack;
   logic              erase_req;
   logic              erase_busy;
   logic              ready;
   logic [ADDR_W-1:0] address;
   logic [15:0]       data_read;
   logic [15:0]       data_write;
   logic              read;
   logic              write;
   logic [3:0]        state;

   modport slave (
      input  vid_req, vid_addr, pen_req, pen_x, pen_y, erase_req,
             ready, data_read,
      output vid_grant, vid_valid, vid_data, pen_ack, erase_busy,
             address, data_write, read, write, state
   );

   modport master (
      output vid_req, vid_addr, pen_req, pen_x, pen_y, erase_req,
             ready, data_read,
      input  vid_grant, vid_valid, vid_data, pen_ack, erase_busy,
             address, data_write, read, write, state
   );
endinterface

// File: rtl/sram_scheduler.sv
// ---------------------------------------------------------------------------
// sram_scheduler
// Shares the single external SRAM port between three requesters:
//   - video line fetch (one 16-pixel word per request),
//   - pen plotting (atomic read-modify-write setting one pixel bit),
//   - full-screen erase (background sweep writing zeros).
// Fixed priority is video > pen > erase. Arbitration happens only in IDLE
// with ready=1, and nothing is preempted. Every SRAM command is a one-cycle
// read/write pulse with address/data registered alongside it. Each pulse is
// followed by one unconditional hold cycle, then a wait for ready.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high; aborts any transaction in flight
//   bus   : sram_scheduler_if.slave (requesters + SRAM controller)
// ---------------------------------------------------------------------------
module sram_scheduler #(
   parameter int ADDR_W         = 18,
   parameter int WORDS_PER_LINE = 40,
   parameter int ERASE_WORDS    = 19200
) (
   input logic              clk,
   input logic              reset,
   sram_scheduler_if.slave  bus
);

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      V_HOLD  = 4'd1,
      V_DONE  = 4'd2,
      P_HOLD  = 4'd3,
      P_MOD   = 4'd4,
      P_WR    = 4'd5,
      P_WHOLD = 4'd6,
      P_WDONE = 4'd7,
      E_HOLD  = 4'd8,
      E_DONE  = 4'd9
   } state_t;

   localparam logic [ADDR_W-1:0] ERASE_LAST = ADDR_W'(ERASE_WORDS - 1);

   state_t            state_q,      state_d;
   logic [ADDR_W-1:0] address_q,    address_d;
   logic [15:0]       dataWrite_q,  dataWrite_d;
   logic              read_q,       read_d;
   logic              write_q,      write_d;
   logic              vidGrant_q,   vidGrant_d;
   logic              vidValid_q,   vidValid_d;
   logic [15:0]       vidData_q,    vidData_d;
   logic              penAck_q,     penAck_d;
   logic              eraseBusy_q,  eraseBusy_d;
   logic [ADDR_W-1:0] erasePtr_q,   erasePtr_d;
   logic [15:0]       penMask_q,    penMask_d;

   logic              penInRange;
   logic [ADDR_W-1:0] penWord;
   logic [15:0]       penBit;

   // Word address of a pixel: x/16 plus y*WORDS_PER_LINE.
   // The multiply is built from shifted copies of y, one per set bit of the
   // constant, so no multiplier or divider is inferred.
   function automatic logic [ADDR_W-1:0] penWordAddr(input logic [9:0] x,
                                                     input logic [9:0] y);
      logic [ADDR_W-1:0] acc;
      acc = ADDR_W'(x[9:4]);
      for (int i = 0; i < 32; i++) begin
         if (WORDS_PER_LINE[i]) begin
            acc = acc + (ADDR_W'(y) << i);
         end
      end
      return acc;
   endfunction

   // Pixel decode for the pen. The MSB of a word is the leftmost pixel.
   always_comb begin
      penInRange = (bus.pen_x < 10'd640) && (bus.pen_y < 10'd480);
      penWord    = penWordAddr(bus.pen_x, bus.pen_y);
      penBit     = 16'h8000 >> bus.pen_x[3:0];
   end

   // Next-state and registered-output logic for the whole scheduler.
   // Command pulses, grants and acks default to 0, so each is high for
   // exactly the one cycle that sets it. Address and write data default to
   // holding, which keeps them stable until the transaction completes.
   // A pen request is not granted in the cycle its ack is showing. The
   // requester only sees the ack in that cycle, so its still-high request
   // is the old one. From the following cycle on, a high pen_req is a new
   // request.
   always_comb begin
      state_d     = state_q;
      address_d   = address_q;
      dataWrite_d = dataWrite_q;
      read_d      = 1'b0;
      write_d     = 1'b0;
      vidGrant_d  = 1'b0;
      vidValid_d  = 1'b0;
      vidData_d   = vidData_q;
      penAck_d    = 1'b0;
      eraseBusy_d = eraseBusy_q;
      erasePtr_d  = erasePtr_q;
      penMask_d   = penMask_q;

      if (bus.erase_req && !eraseBusy_q) begin
         eraseBusy_d = 1'b1;
         erasePtr_d  = '0;
      end

      case (state_q)
         IDLE: begin
            if (bus.ready) begin
               if (bus.vid_req) begin
                  address_d  = bus.vid_addr;
                  read_d     = 1'b1;
                  vidGrant_d = 1'b1;
                  state_d    = V_HOLD;
               end else if (bus.pen_req && !penAck_q) begin
                  if (penInRange) begin
                     address_d = penWord;
                     penMask_d = penBit;
                     read_d    = 1'b1;
                     state_d   = P_HOLD;
                  end else begin
                     penAck_d  = 1'b1;
                  end
               end else if (eraseBusy_q) begin
                  address_d   = erasePtr_q;
                  dataWrite_d = 16'h0000;
                  write_d     = 1'b1;
                  state_d     = E_HOLD;
               end
            end
         end
         V_HOLD:  state_d = V_DONE;
         V_DONE: begin
            if (bus.ready) begin
               vidData_d  = bus.data_read;
               vidValid_d = 1'b1;
               state_d    = IDLE;
            end
         end
         P_HOLD:  state_d = P_MOD;
         P_MOD: begin
            if (bus.ready) begin
               dataWrite_d = bus.data_read | penMask_q;
               state_d     = P_WR;
            end
         end
         P_WR: begin
            if (bus.ready) begin
               write_d = 1'b1;
               state_d = P_WHOLD;
            end
         end
         P_WHOLD: state_d = P_WDONE;
         P_WDONE: begin
            if (bus.ready) begin
               penAck_d = 1'b1;
               state_d  = IDLE;
            end
         end
         E_HOLD:  state_d = E_DONE;
         E_DONE: begin
            if (bus.ready) begin
               if (erasePtr_q == ERASE_LAST) begin
                  eraseBusy_d = 1'b0;
                  erasePtr_d  = '0;
               end else begin
                  erasePtr_d  = erasePtr_q + 1'b1;
               end
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers. Reset clears everything, including the
   // erase pointer and the latched pen word/bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         address_q   <= '0;
         dataWrite_q <= '0;
         read_q      <= 1'b0;
         write_q     <= 1'b0;
         vidGrant_q  <= 1'b0;
         vidValid_q  <= 1'b0;
         vidData_q   <= '0;
         penAck_q    <= 1'b0;
         eraseBusy_q <= 1'b0;
         erasePtr_q  <= '0;
         penMask_q   <= '0;
      end else begin
         state_q     <= state_d;
         address_q   <= address_d;
         dataWrite_q <= dataWrite_d;
         read_q      <= read_d;
         write_q     <= write_d;
         vidGrant_q  <= vidGrant_d;
         vidValid_q  <= vidValid_d;
         vidData_q   <= vidData_d;
         penAck_q    <= penAck_d;
         eraseBusy_q <= eraseBusy_d;
         erasePtr_q  <= erasePtr_d;
         penMask_q   <= penMask_d;
      end
   end

   assign bus.address    = address_q;
   assign bus.data_write = dataWrite_q;
   assign bus.read       = read_q;
   assign bus.write      = write_q;
   assign bus.vid_grant  = vidGrant_q;
   assign bus.vid_valid  = vidValid_q;
   assign bus.vid_data   = vidData_q;
   assign bus.pen_ack    = penAck_q;
   assign bus.erase_busy = eraseBusy_q;
   assign bus.state      = state_q;

endmodule
